mem_arbiter_mc: RTL and testbench
=================================

// Module: mem_arbiter_mc
// PURPOSE
//  Parametrised multi-channel arbiter between NUM_CH requesters (IF, MEM, ...) and the byte-wide external memory bus.
//  Serialises 1..MAX_B byte transfers: little-endian, pipelined reads at 1 byte/cycle.
//  Replaces the fixed 2-port controller. Adds N channels, round-robin/fixed priority and clean rdy freeze/replay.
// PARAMETERS
//  NUM_CH  2   number of requesting channels; channel 0 has top priority in fixed mode
//  ADDR_W  32  address width
//  MAX_B   4   max bytes per transfer; DATA_W = 8*MAX_B
//  RR_EN   0   0: fixed priority (lowest index wins); 1: round-robin starting after last granted
// PORTS
//  clk        in   1               system clock, rising edge
//  rst        in   1               asynchronous reset, active-low
//  rdy        in   1               chip enable; low freezes the block
//  req_valid  in   NUM_CH          request per channel; held high until that channel's done
//  req_wr     in   NUM_CH          1 = write, 0 = read
//  req_addr   in   NUM_CH*ADDR_W   start byte address, packed by channel
//  req_len    in   NUM_CH*3        byte count 1..MAX_B; 0 or >MAX_B treated as 1
//  req_wdata  in   NUM_CH*DATA_W   write data; byte i = [8i+7:8i]
//  done       out  NUM_CH          one-cycle pulse on the completing channel
//  rdata      out  DATA_W          read result, valid while done; unfetched upper bytes = 0
//  busy       out  1               high in any state other than IDLE
//  mem_a      out  ADDR_W          memory address
//  mem_dout   out  8               write byte
//  mem_wr     out  1               1 = write this cycle
//  mem_din    in   8               read byte, for the address driven in the previous cycle
// BEHAVIOUR
//  Reset (async, rst=0):
//   - state=IDLE
//   - done=0, rdata=0, busy=0, mem_a=0, mem_dout=0, mem_wr=0
//   - RR pointer = NUM_CH-1, so channel 0 is searched first
//   - an in-flight transfer is dropped with no done
//  FSM: IDLE -> ACCESS -> DONE -> IDLE
//   - IDLE: at edge E0, if any req_valid is set, grant one channel.
//     Latch that channel's wr/addr/len/wdata, clear issue counter ic and capture counter cc, go to ACCESS.
//     With no request, stay in IDLE; bus at reset values.
//   - ACCESS, write: drive mem_a=addr+ic, mem_dout=byte ic, mem_wr=1.
//     After byte len-1 (edge E0+len), go to DONE.
//   - ACCESS, read: drive mem_a=addr+ic while ic<len, mem_wr=0.
//     Issue byte i in cycle E0+i. Capture mem_din into rdata byte cc at edge E0+i+2.
//     After capturing byte len-1 (edge E0+len+1), go to DONE.
//   - DONE: done[ch]=1 for exactly one cycle, rdata stable, bus idle. Then IDLE.
//     The requester must drop req_valid by the end of DONE, or it is granted again.
//  Arbitration: evaluated only in IDLE; a granted transfer is never preempted.
//   - RR_EN=1: search from last_grant+1 modulo NUM_CH; update last_grant on grant.
//  Address: addr+ic wraps modulo 2^ADDR_W.
//  rdy=0:
//   - state, counters and latched data hold; mem_wr forced 0; no capture; done held off.
//   - A pending DONE pulse is emitted in the first rdy=1 cycle.
//   - Read resume: in the first rdy=1 cycle, set ic=cc and reissue the uncaptured byte (one bubble, no byte skipped or duplicated).
//   - Write resume: the byte that was suppressed is reissued.
//  Latency with rdy=1 throughout:
//   - read: done in cycle E0+len+1
//   - write: done in cycle E0+len
//   - back-to-back grants are separated by one DONE cycle plus the IDLE arbitration edge
// TESTING
//  1. Read, ch0, addr 0x100, len 4; mem returns 11,22,33,44 -> mem_a 0x100..0x103 on consecutive cycles, done[0] at E0+5, rdata=0x44332211.
//  2. Write, ch1, addr 0x2000, len 2, wdata 0xBEEF -> mem_wr=1 with (0x2000,EF) then (0x2001,BE), done[1] at E0+2.
//  3. ch0 and ch1 valid together, RR_EN=0 -> ch0 served first; RR_EN=1 with last=0 -> ch1 served first.
//  4. Read len 4, rdy low for 3 cycles after byte 1 is issued -> no mem_wr, byte 1 reissued on resume, rdata still correct, done delayed by 4 cycles.
//  5. rst asserted mid-read (cc=2) -> all outputs 0 immediately, no done; after release, a new ch1 request completes normally.
//  6. len=1 read at 0xFFFFFFFF; len=4 read at 0xFFFFFFFE -> second read wraps: mem_a FE,FF,00,01 (low byte shown); first returns 1 byte, upper rdata=0.

Source files
------------

// File: rtl/mem_arbiter_mc.sv
// Multi-channel arbiter onto a byte-wide external memory bus.
// Serialises 1..MAX_B byte little-endian transfers; reads are pipelined one byte per cycle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | bus idle, arbitrate among req_valid, latch the winner
// ST_ACCESS | issue bytes (write) or issue/capture bytes (read)
// ST_DONE   | pulse done for the granted channel, rdata stable
module mem_arbiter_mc #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int MAX_B  = 4,
  parameter int RR_EN  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH-1:0]         req_wr,
  input  logic [NUM_CH*ADDR_W-1:0]  req_addr,
  input  logic [NUM_CH*3-1:0]       req_len,
  input  logic [NUM_CH*8*MAX_B-1:0] req_wdata,
  output logic [NUM_CH-1:0]         done,
  output logic [8*MAX_B-1:0]        rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_a,
  output logic [7:0]                mem_dout,
  output logic                      mem_wr,
  input  logic [7:0]                mem_din
);

  localparam int         DATA_W = 8*MAX_B;
  localparam int         CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0] MAX_L  = 3'(MAX_B);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q;
  logic [CH_W-1:0]     last_grant_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          len_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          ic_q;
  logic [2:0]          cc_q;
  logic                pend_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                any_req;
  logic [CH_W-1:0]     gnt;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [2:0]          sel_len_raw;
  logic [2:0]          sel_len;
  logic [DATA_W-1:0]   sel_wdata;
  int                  best_d;
  int                  cand_d;

  logic                issue;
  logic                wr_fire;
  logic                last_cap;
  logic                last_wr;

  // Winner = smallest search distance; distance is the channel index in fixed
  // mode, or the offset from last_grant+1 in round-robin mode.
  always_comb begin
    any_req     = |req_valid;
    gnt         = '0;
    sel_wr      = 1'b0;
    sel_addr    = '0;
    sel_len_raw = '0;
    sel_wdata   = '0;
    best_d      = NUM_CH;
    cand_d      = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      cand_d = (RR_EN != 0) ? ((c + 2*NUM_CH - int'(last_grant_q) - 1) % NUM_CH) : c;
      if (req_valid[c] && (cand_d < best_d)) begin
        best_d      = cand_d;
        gnt         = CH_W'(c);
        sel_wr      = req_wr[c];
        sel_addr    = req_addr[c*ADDR_W +: ADDR_W];
        sel_len_raw = req_len[c*3 +: 3];
        sel_wdata   = req_wdata[c*DATA_W +: DATA_W];
      end
    end
    sel_len = ((sel_len_raw == 3'd0) || (sel_len_raw > MAX_L)) ? 3'd1 : sel_len_raw;
  end

  assign issue    = (state_q == ST_ACCESS) && !wr_q && (ic_q < len_q) && rdy;
  assign wr_fire  = (state_q == ST_ACCESS) && wr_q && rdy;
  assign last_wr  = wr_fire && (ic_q == len_q - 3'd1);
  assign last_cap = (state_q == ST_ACCESS) && !wr_q && rdy && pend_q &&
                    (cc_q == len_q - 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rdy && any_req) state_d = ST_ACCESS;
      ST_ACCESS: if (wr_q ? last_wr : last_cap) state_d = ST_DONE;
      ST_DONE:   if (rdy) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q         <= '0;
      last_grant_q <= CH_W'(NUM_CH-1);
      wr_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= 3'd1;
      wdata_q      <= '0;
      ic_q         <= '0;
      cc_q         <= '0;
      pend_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rdy && any_req) begin
            ch_q         <= gnt;
            last_grant_q <= gnt;
            wr_q         <= sel_wr;
            addr_q       <= sel_addr;
            len_q        <= sel_len;
            wdata_q      <= sel_wdata;
            ic_q         <= '0;
            cc_q         <= '0;
            pend_q       <= 1'b0;
            rdata_q      <= '0;
          end
        end
        ST_ACCESS: begin
          if (!rdy) begin
            // The byte in flight is lost while frozen; rewind so it is reissued.
            pend_q <= 1'b0;
            if (!wr_q) ic_q <= cc_q;
          end else if (wr_q) begin
            ic_q <= ic_q + 3'd1;
          end else begin
            pend_q <= issue;
            if (issue) ic_q <= ic_q + 3'd1;
            if (pend_q) begin
              for (int b = 0; b < MAX_B; b++)
                if (cc_q == 3'(b)) rdata_q[8*b +: 8] <= mem_din;
              cc_q <= cc_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    mem_wr   = wr_fire;
    mem_a    = '0;
    mem_dout = '0;
    done     = '0;
    if ((state_q == ST_ACCESS) && (wr_q || (ic_q < len_q)))
      mem_a = addr_q + ADDR_W'(ic_q);
    if ((state_q == ST_ACCESS) && wr_q) begin
      for (int b = 0; b < MAX_B; b++)
        if (ic_q == 3'(b)) mem_dout = wdata_q[8*b +: 8];
    end
    for (int c = 0; c < NUM_CH; c++)
      done[c] = (state_q == ST_DONE) && rdy && (ch_q == CH_W'(c));
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Directed bench for mem_arbiter_mc: vector table of single transfers plus
// hand sequences for arbitration, rdy freeze/replay and mid-transfer reset.
module tb_mem_arbiter_mc;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [1:0]  req_valid;
  logic [1:0]  req_wr;
  logic [63:0] req_addr;
  logic [5:0]  req_len;
  logic [63:0] req_wdata;

  logic [1:0]  done,   rr_done;
  logic [31:0] rdata,  rr_rdata;
  logic        busy,   rr_busy;
  logic [31:0] mem_a,  rr_mem_a;
  logic [7:0]  mem_dout, rr_mem_dout;
  logic        mem_wr, rr_mem_wr;
  logic [7:0]  mem_din_f, mem_din_r;

  mem_arbiter_mc #(.NUM_CH(2), .ADDR_W(32), .MAX_B(4), .RR_EN(0)) u_fix (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .done(done), .rdata(rdata), .busy(busy), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din_f));

  mem_arbiter_mc #(.NUM_CH(2), .ADDR_W(32), .MAX_B(4), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .done(rr_done), .rdata(rr_rdata), .busy(rr_busy), .mem_a(rr_mem_a),
    .mem_dout(rr_mem_dout), .mem_wr(rr_mem_wr), .mem_din(mem_din_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: unwritten locations read as addr[7:0]^5A, one cycle latency.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    mem_din_f <= rd(mem_a);
    mem_din_r <= rd(rr_mem_a);
    if (mem_wr) mem[mem_a] = mem_dout;
  end

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [15:0] rdy_lo;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] tr_a  [40];
  logic        tr_wr [40];
  logic [7:0]  tr_do [40];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One transfer on one channel; the other channel's fields hold decoy values.
  task automatic run(input vec_t v);
    int   lat;
    bit   got;
    int   el;
    logic [1:0] m;
    el = ((v.len == 3'd0) || (v.len > 3'd4)) ? 1 : int'(v.len);
    m = '0;
    m[v.ch] = 1'b1;
    @(posedge clk);
    #1;
    req_valid = m;
    req_wr    = v.wr ? m : ~m;
    req_addr  = {2{~v.addr}};
    req_len   = {2{3'd3}};
    req_wdata = {2{~v.wdata}};
    req_addr[v.ch*32 +: 32]  = v.addr;
    req_len[v.ch*3 +: 3]     = v.len;
    req_wdata[v.ch*32 +: 32] = v.wdata;
    @(posedge clk);
    got = 0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      #1 rdy = (k < 16) ? !v.rdy_lo[k] : 1'b1;
      @(negedge clk);
      tr_a[k]  = mem_a;
      tr_wr[k] = mem_wr;
      tr_do[k] = mem_dout;
      if (got) begin
        chk("done_single_pulse", {62'd0, done}, 64'd0);
        break;
      end
      if (done != 2'b00) begin
        got = 1;
        lat = k;
        chk("done_channel", {62'd0, done}, {62'd0, m});
        if (!v.wr) chk("rdata", {32'd0, rdata}, {32'd0, v.exp_rdata});
        req_valid = '0;
      end
      @(posedge clk);
    end
    rdy = 1'b1;
    if (!got) chk("done_timeout", 64'd1, 64'd0);
    else      chk("latency", 64'(lat), 64'(v.exp_lat));
    if (v.rdy_lo == 16'd0) begin
      for (int k = 0; k < el; k++) begin
        chk("bus_addr", {32'd0, tr_a[k]}, {32'd0, v.addr + 32'(k)});
        chk("bus_wr", {63'd0, tr_wr[k]}, {63'd0, v.wr});
        if (v.wr) chk("bus_dout", {56'd0, tr_do[k]}, {56'd0, v.wdata[8*k +: 8]});
      end
    end
  endtask

  vec_t tbl [11];
  vec_t fa, fb, fc, pr;

  initial begin
    tbl[0]  = '{0, 1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h4433_2211, 5, 16'h0};
    tbl[1]  = '{1, 1'b1, 32'h0000_2000, 3'd2, 32'h0000_BEEF, 32'h0,         2, 16'h0};
    tbl[2]  = '{0, 1'b0, 32'h0000_2000, 3'd2, 32'h0,         32'h0000_BEEF, 3, 16'h0};
    tbl[3]  = '{1, 1'b0, 32'hFFFF_FFFF, 3'd1, 32'h0,         32'h0000_00A5, 2, 16'h0};
    tbl[4]  = '{0, 1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0,         32'h5B5A_A5A4, 5, 16'h0};
    tbl[5]  = '{1, 1'b1, 32'h0000_0300, 3'd3, 32'h00CC_BBAA, 32'h0,         3, 16'h0};
    tbl[6]  = '{1, 1'b0, 32'h0000_0300, 3'd0, 32'h0,         32'h0000_00AA, 2, 16'h0};
    tbl[7]  = '{0, 1'b0, 32'h0000_0300, 3'd7, 32'h0,         32'h0000_00AA, 2, 16'h0};
    tbl[8]  = '{0, 1'b0, 32'h0000_0301, 3'd3, 32'h0,         32'h0059_CCBB, 4, 16'h0};
    tbl[9]  = '{1, 1'b1, 32'h0000_0400, 3'd4, 32'hDEAD_BEEF, 32'h0,         4, 16'h0};
    tbl[10] = '{0, 1'b0, 32'h0000_0400, 3'd4, 32'h0,         32'hDEAD_BEEF, 5, 16'h0};
    fa = '{0, 1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h4433_2211, 9, 16'h001C};
    fb = '{1, 1'b1, 32'h0000_0500, 3'd2, 32'h0000_7788, 32'h0,         6, 16'h0036};
    fc = '{0, 1'b0, 32'h0000_0500, 3'd2, 32'h0,         32'h0000_7788, 3, 16'h0};
    pr = '{1, 1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h4433_2211, 5, 16'h0};

    mem[32'h100] = 8'h11;
    mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33;
    mem[32'h103] = 8'h44;

    rst = 1'b0; rdy = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    #12;
    chk("reset_bus", {22'd0, busy, mem_a, mem_dout, mem_wr}, 64'd0);
    chk("reset_out", {30'd0, done, rdata}, 64'd0);
    chk("reset_rr", {60'd0, rr_done, rr_busy, rr_mem_wr}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_req", {22'd0, busy, mem_a, mem_dout, mem_wr}, 64'd0);

    for (int i = 0; i < 11; i++) run(tbl[i]);

    // Both channels at once; last grant was ch0 on both instances.
    for (int r = 0; r < 2; r++) begin
      bit seen;
      @(posedge clk);
      #1;
      req_valid = 2'b11; req_wr = 2'b00; req_len = {3'd1, 3'd1};
      req_addr  = {32'h0000_0101, 32'h0000_0100};
      @(posedge clk);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done != 2'b00 || rr_done != 2'b00) begin
          seen = 1;
          chk("fixed_prio_done", {62'd0, done}, 64'd1);
          chk("fixed_prio_rdata", {32'd0, rdata}, 64'h11);
          chk("rr_done", {62'd0, rr_done}, (r == 0) ? 64'd2 : 64'd1);
          chk("rr_rdata", {32'd0, rr_rdata}, (r == 0) ? 64'h22 : 64'h11);
          req_valid = '0;
          break;
        end
      end
      if (!seen) chk("arb_timeout", 64'd1, 64'd0);
      @(negedge clk);
    end

    run(fa);
    chk("frz_rd_no_wr", {61'd0, tr_wr[2], tr_wr[3], tr_wr[4]}, 64'd0);
    chk("frz_rd_reissue", {32'd0, tr_a[5]}, 64'h101);
    chk("frz_rd_next", {32'd0, tr_a[6]}, 64'h102);

    run(fb);
    chk("frz_wr_byte0", {23'd0, tr_wr[0], tr_a[0], tr_do[0]}, {23'd0, 1'b1, 32'h500, 8'h88});
    chk("frz_wr_hold", {62'd0, tr_wr[1], tr_wr[2]}, 64'd0);
    chk("frz_wr_replay", {23'd0, tr_wr[3], tr_a[3], tr_do[3]}, {23'd0, 1'b1, 32'h501, 8'h77});
    run(fc);

    // Reset in the middle of a read, after two bytes have been captured.
    @(posedge clk);
    #1;
    req_valid = 2'b01; req_wr = 2'b00;
    req_addr = {32'h0, 32'h0000_0100}; req_len = {3'd1, 3'd4};
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_reset_bus", {22'd0, busy, mem_a, mem_dout, mem_wr}, 64'd0);
    chk("mid_reset_out", {30'd0, done, rdata}, 64'd0);
    req_valid = '0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", {61'd0, done, busy}, 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", {61'd0, done, busy}, 64'd0);
    run(pr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
